mac_share_arbiter: RTL and testbench

//   Shares one mac_unit10 datapath (a*b + c, 16-bit unsigned operands, 32-bit result) between

---
 rtl/mac_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_mac_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: shares a single mac_unit10 (a*b + c, 16-bit unsigned
// operands, 32-bit result) between NREQ requesters with round-robin
// arbitration. Only one operation is in flight at a time.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous reset, active-high
//   req_valid  [NREQ]      per-requester operation request
//   req_ready  [NREQ]      per-requester accept (one-hot or zero, IDLE only)
//   req_a/b/c  [NREQ*16]   operands, requester i at [16*i +: 16]
//   rsp_valid  result available
//   rsp_ready  result consumer accept
//   rsp_data   [32]        a*b + c of the accepted operation
//   rsp_id     [IDW]       index of the requester that issued the operation
//   busy       high whenever the FSM is not in IDLE
//
// Pipeline: IDLE accept -> operand regs (_p0) -> CALC: MAC output registered
// into rsp_data -> HOLD until the consumer takes it.

module mac_unit10 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [31:0] y
);
  // Max 0xFFFE0001 + 0xFFFF = 0xFFFF0000, so 32 bits never overflow.
  assign y = (32'(a) * 32'(b)) + {16'b0, c};
endmodule

module mac_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*16-1:0]      req_a,
  input  logic [NREQ*16-1:0]      req_b,
  input  logic [NREQ*16-1:0]      req_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;

  logic [15:0]      op_a_p0;
  logic [15:0]      op_b_p0;
  logic [15:0]      op_c_p0;
  logic [IDW-1:0]   op_id_p0;
  logic [31:0]      mac_y;

  // Round-robin scan starting just after the last granted requester.
  // One extra bit in scan_sum lets rr_ptr + k exceed NREQ before wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Accept is only offered while idle; at most one bit is ever set.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  mac_unit10 u_mac (
    .a (op_a_p0),
    .b (op_b_p0),
    .c (op_c_p0),
    .y (mac_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ-1);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_c_p0   <= '0;
      op_id_p0  <= '0;
    end else begin
      case (state)
        // Stage p0: latch the granted requester's operands.
        IDLE: begin
          if (grant_vld) begin
            op_a_p0  <= req_a[{grant_idx, 4'b0000} +: 16];
            op_b_p0  <= req_b[{grant_idx, 4'b0000} +: 16];
            op_c_p0  <= req_c[{grant_idx, 4'b0000} +: 16];
            op_id_p0 <= grant_idx;
            rr_ptr   <= grant_idx;
            state    <= CALC;
            busy     <= 1'b1;
          end
        end
        // Stage p1: register the MAC result and tag it with the requester.
        CALC: begin
          rsp_data  <= mac_y;
          rsp_id    <= op_id_p0;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        // Response held stable until the consumer accepts it.
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
module tb_mac_share_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic [NREQ*16-1:0] req_c = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  mac_share_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Operand tables per requester
  logic [15:0] ta [NREQ];
  logic [15:0] tb_ [NREQ];
  logic [15:0] tc [NREQ];

  // Transaction-level reference: a single slot, the last served requester,
  // and the cycles left before the result shows up.
  bit          m_idle = 1'b1;
  int          m_wait = 0;
  bit          m_vld  = 1'b0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_id   = '0;
  logic [31:0] m_pend_data = '0;
  logic [1:0]  m_pend_id   = '0;
  int          m_last = NREQ-1;
  bit          armed  = 1'b0;
  int          cyc    = 0;

  int          seen_id [$];
  int          seen_cyc [$];

  task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic r);
    logic [NREQ-1:0] exp_rdy;
    int g;
    @(negedge clk);
    cyc++;
    if (armed) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      chk("rsp_data",  rsp_data, m_data);
      chk("rsp_id",    32'(rsp_id), 32'(m_id));
      chk("busy",      32'(busy), 32'(!m_idle));
      if (rsp_valid) begin
        seen_id.push_back(int'(rsp_id));
        seen_cyc.push_back(cyc);
      end
    end
    req_valid = v;
    rsp_ready = rr;
    rst       = r;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = ta[i];
      req_b[16*i +: 16] = tb_[i];
      req_c[16*i +: 16] = tc[i];
    end
    #1;
    exp_rdy = '0;
    g = -1;
    if (m_idle) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (g < 0 && v[i]) g = i;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    end
    if (r) begin
      m_idle = 1'b1; m_wait = 0; m_vld = 1'b0;
      m_data = '0; m_id = '0; m_last = NREQ-1;
    end else if (m_idle) begin
      if (g >= 0) begin
        m_last      = g;
        m_pend_data = 32'(ta[g]) * 32'(tb_[g]) + 32'(tc[g]);
        m_pend_id   = 2'(g);
        m_idle      = 1'b0;
        m_wait      = 1;
      end
    end else if (m_wait > 0) begin
      m_wait = 0;
      m_vld  = 1'b1;
      m_data = m_pend_data;
      m_id   = m_pend_id;
    end else if (rr) begin
      m_vld  = 1'b0;
      m_idle = 1'b1;
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    ta[i] = a; tb_[i] = b; tc[i] = c;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'h0, 16'h0, 16'h0);

    // Reset
    step('0, 1'b0, 1'b1);
    armed = 1'b1;
    step('0, 1'b0, 1'b0);

    // Requester 1 alone: 3*4+5
    set_ops(1, 16'd3, 16'd4, 16'd5);
    step(4'b0010, 1'b1, 1'b0);
    chk("t1_ready", 32'(req_ready), 32'h2);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t1_data", rsp_data, 32'd17);
    chk("t1_id", 32'(rsp_id), 32'd1);
    step(4'b0000, 1'b1, 1'b0);

    // Extremes on requester 0
    set_ops(0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t2_max", rsp_data, 32'hFFFF0000);
    set_ops(0, 16'h0, 16'h1234, 16'hABCD);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t2_zero_a", rsp_data, 32'h0000ABCD);

    // All four requesting from a fresh reset: ids 0,1,2,3,0 every 3 cycles
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'(100 + i), 16'(7 * i + 1), 16'(i));
    seen_id.delete();
    seen_cyc.delete();
    for (int n = 0; n < 16; n++) step(4'b1111, 1'b1, 1'b0);
    if (seen_id.size() < 5) begin
      chk("t3_count", 32'(seen_id.size()), 32'd5);
    end else begin
      for (int n = 0; n < 5; n++) chk("t3_id_seq", 32'(seen_id[n]), 32'(n % NREQ));
      for (int n = 1; n < 5; n++) chk("t3_spacing", 32'(seen_cyc[n] - seen_cyc[n-1]), 32'd3);
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // Back-pressure: response held for 5 cycles with requests pending
    step('0, 1'b1, 1'b1);
    set_ops(2, 16'h1111, 16'h2222, 16'h3333);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step(4'b1111, 1'b0, 1'b0);
    chk("t4_ready_blocked", 32'(req_ready), 32'h0);
    chk("t4_busy", 32'(busy), 32'd1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t4_released", 32'(busy), 32'd0);

    // Reset during CALC drops the operation
    set_ops(3, 16'h0005, 16'h0006, 16'h0007);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b0);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_grant0", 32'(req_ready), 32'h0);
    step(4'b1001, 1'b1, 1'b0);
    chk("t5_grant_req0", 32'(req_ready), 32'h1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Wrap-around: after req2, req0 beats req2
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    chk("t6_wrap", 32'(req_ready), 32'h1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom));
      step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end
    step('0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
